grom_io_input: RTL and testbench

CPU-facing input peripheral for the grom8 I/O space, the read-side counterpart of the display output register. External producers push bytes through a valid/ready handshake into a small FIFO. The CPU pops them with I/O reads (`ioreq`=1, `we`=0) on a data port and polls occupancy on a status port. The block sits beside the display latch in `grom_computer`, sharing `addr`/`ioreq`/`we`. Its `io_data_out` is muxed onto the CPU `data_in` when `ioreq`=1.

---
 rtl/grom_io_input.sv | 151 +++++++++++++++
 tb/tb_grom_io_input.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/grom_io_input.sv
// grom8 I/O input peripheral: producer bytes enter a small FIFO and the CPU pops them on the data port or polls the status port.
// Optional sticky overrun flag in status bit 2 when GROM_IO_OVERRUN_EN is defined.
module grom_io_input #(
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  PORT_BASE = 8'h10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] addr,
    input  logic        ioreq,
    input  logic        we,
    output logic [7:0]  io_data_out,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    dout_q, dout_d;
    logic          sel_q;

    logic          sel_s;
    logic          rd_s;
    logic          data_rd_s;
    logic          stat_rd_s;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          ovr_s;
    logic [3:0]    count4_s;
    logic [7:0]    status_s;

    assign sel_s     = ioreq & ~we & (addr[7:1] == PORT_BASE[7:1]);
    assign rd_s      = sel_s & ~sel_q;
    assign data_rd_s = rd_s & ~addr[0];
    assign stat_rd_s = rd_s & addr[0];

    assign empty_s   = (count_q == CNT_ZERO);
    assign full_s    = (count_q == CNT_FULL);
    assign in_ready  = ~full_s;
    assign push_s    = in_valid & ~full_s;
    // An empty FIFO pop returns zero and must not disturb a coincident push.
    assign pop_s     = data_rd_s & ~empty_s;

    assign count4_s  = 4'(count_q);
    assign status_s  = {count4_s, 1'b0, ovr_s, full_s, ~empty_s};
    assign io_data_out = dout_q;

`ifdef GROM_IO_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Sticky overrun: set on a dropped byte, cleared by a status read; set wins.
    always_comb begin
        ovr_d = ovr_q;
        if (in_valid & full_s) begin
            ovr_d = 1'b1;
        end else if (stat_rd_s) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Overrun flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr_s = ovr_q;
`else
    assign ovr_s = 1'b0;
`endif

    // Pointer, occupancy and read-data next state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (data_rd_s) begin
            if (!empty_s) begin
                dout_d = mem_q[rd_ptr_q];
            end else begin
                dout_d = 8'h00;
            end
        end else if (stat_rd_s) begin
            dout_d = status_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // Control state; reset forgets any sel run in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= 8'h00;
            sel_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            sel_q    <= sel_s;
        end
    end

    // FIFO storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_grom_io_input.sv
// Scoreboard bench for grom_io_input (DEPTH=4, PORT_BASE=8'h10).
module tb_grom_io_input;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] addr;
    logic        ioreq;
    logic        we;
    logic [7:0]  io_data_out;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    grom_io_input #(.DEPTH(4), .PORT_BASE(8'h10)) dut (
        .clk(clk), .reset(reset), .addr(addr), .ioreq(ioreq), .we(we),
        .io_data_out(io_data_out), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready)
    );

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: a read access is the rising edge of the selected, non-write I/O cycle.
    initial begin : monitor
        logic sel_prev;
        logic sel_now;
        logic [7:0] e;
        string nm;
        sel_prev = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                sel_prev = 1'b0;
            end else begin
                sel_now = ioreq & ~we & (addr[7:1] == 7'h08);
                if (sel_now && !sel_prev) begin
                    sel_prev = sel_now;
                    @(negedge clk);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_read: got %h required none", io_data_out);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        check8(nm, io_data_out, e);
                    end
                end else begin
                    sel_prev = sel_now;
                end
            end
        end
    end

    task automatic expect_rd(input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic io_rd(input logic [11:0] a, input logic [7:0] e, input string nm, input int hold);
        expect_rd(e, nm);
        @(negedge clk);
        addr = a; ioreq = 1'b1; we = 1'b0;
        repeat (hold) @(negedge clk);
        ioreq = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1; in_data = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] full_ovr;
        int budget;
`ifdef GROM_IO_OVERRUN_EN
        full_ovr = 8'h47;
`else
        full_ovr = 8'h43;
`endif
        reset = 1'b0; addr = 12'h000; ioreq = 1'b0; we = 1'b0;
        in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check8("reset_dout", io_data_out, 8'h00);
        check8("reset_ready", {7'd0, in_ready}, 8'h01);
        reset = 1'b1;

        io_rd(12'h011, 8'h00, "status_after_reset", 1);

        push(8'hA5); push(8'h3C);
        io_rd(12'h010, 8'hA5, "data_first", 1);
        io_rd(12'h310, 8'h3C, "data_second_hiaddr", 1);
        io_rd(12'h011, 8'h00, "status_drained", 1);

        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        check8("full_ready", {7'd0, in_ready}, 8'h00);
        io_rd(12'h011, 8'h43, "status_full", 1);
        push(8'h55);
        io_rd(12'h011, full_ovr, "status_overrun", 1);
        io_rd(12'h011, 8'h43, "status_reread", 1);
        io_rd(12'h010, 8'h11, "wrap_d0", 1);
        check8("ready_after_pop", {7'd0, in_ready}, 8'h01);
        io_rd(12'h010, 8'h22, "wrap_d1", 1);
        io_rd(12'h010, 8'h33, "wrap_d2", 1);
        io_rd(12'h010, 8'h44, "wrap_d3_no55", 1);

        // Unselected port must not pop.
        push(8'h66); push(8'h67);
        @(negedge clk); addr = 12'h012; ioreq = 1'b1;
        @(negedge clk); ioreq = 1'b0;
        io_rd(12'h010, 8'h66, "held_read_once", 3);
        io_rd(12'h011, 8'h11, "status_after_held", 1);
        io_rd(12'h010, 8'h67, "data_after_held", 1);

        // Empty pop with coincident push.
        expect_rd(8'h00, "empty_pop_with_push");
        @(negedge clk);
        addr = 12'h010; ioreq = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        ioreq = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        io_rd(12'h010, 8'h77, "pushed_during_pop", 1);

        push(8'h01); push(8'h02); push(8'h03);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check8("midq_reset_dout", io_data_out, 8'h00);
        check8("midq_reset_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        io_rd(12'h011, 8'h00, "status_after_midq_reset", 1);

        // sel held across a reset pulse counts as a fresh read.
        push(8'hC1);
        expect_rd(8'h11, "status_before_pulse");
        expect_rd(8'h00, "status_after_pulse");
        @(negedge clk);
        addr = 12'h011; ioreq = 1'b1; we = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ioreq = 1'b0;
        @(negedge clk);

        // I/O writes are ignored.
        push(8'h9A);
        @(negedge clk);
        addr = 12'h010; ioreq = 1'b1; we = 1'b1;
        repeat (2) @(negedge clk);
        ioreq = 1'b0; we = 1'b0;
        io_rd(12'h011, 8'h11, "status_after_write", 1);
        io_rd(12'h010, 8'h9A, "data_after_write", 1);

        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
